// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm
// Miss-handling controller sitting between one cache and the shared pipelined
// main memory. A miss latches the containing block's base address. The FSM then
// issues one word read per cycle for the whole block and writes each returned
// word into the cache data array as it arrives. The tag/valid entry is written
// only when the final word of the block lands, so an aborted fill never leaves a
// half-filled block marked valid.
//
// The issue side and the receive side are tracked by separate counters. This lets
// returning data for early words overlap with requests that are still going out.
// Completion depends only on how many valids have arrived, not on memory latency,
// so gaps between returned words are harmless.

module cache_fill_fsm #(
   parameter int WORDS_PER_BLK = 8,
   parameter int ADDR_W        = 16
) (
   input  logic                             i_clk,
   input  logic                             i_rst,
   input  logic                             i_miss_detected,
   input  logic [ADDR_W-1:0]                i_miss_address,
   output logic                             o_fsm_busy,
   output logic                             o_memory_en,
   output logic [ADDR_W-1:0]                o_memory_address,
   input  logic                             i_memory_data_valid,
   input  logic [15:0]                      i_memory_data,
   output logic                             o_write_data_array,
   output logic [$clog2(WORDS_PER_BLK)-1:0] o_cache_word,
   output logic [15:0]                      o_cache_data,
   output logic                             o_write_tag_array,
   output logic                             o_fill_done,
   output logic [ADDR_W-1:0]                o_block_base
);

   // Word index width, and counter width with one extra bit so the issue
   // counter can hold the "all requests sent" value WORDS_PER_BLK.
   localparam int WORD_IDX_W = $clog2(WORDS_PER_BLK);
   localparam int CNT_W      = WORD_IDX_W + 1;
   localparam int BLK_BYTES  = 2 * WORDS_PER_BLK;

   // Clearing the low address bits gives the block base (16'hFFF0 for 8 words).
   localparam logic [ADDR_W-1:0] BLK_MASK  = ~(ADDR_W'(BLK_BYTES - 1));
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(WORDS_PER_BLK);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WORDS_PER_BLK - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ZERO  = '0;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } fillState_t;

   fillState_t        r_state;
   fillState_t        w_nextState;
   logic [ADDR_W-1:0] r_blockBase;
   logic [ADDR_W-1:0] w_nextBlockBase;
   logic [CNT_W-1:0]  r_issueCnt;
   logic [CNT_W-1:0]  w_nextIssueCnt;
   logic [CNT_W-1:0]  r_recvCnt;
   logic [CNT_W-1:0]  w_nextRecvCnt;

   // The request address is the block base plus a byte offset of two per word.
   // The sum is kept at ADDR_W bits, so a block at the top of the address space
   // wraps its offsets inside the block and never carries out of the top bit.
   logic [ADDR_W-1:0] w_issueAddr;
   assign w_issueAddr = r_blockBase + ADDR_W'({r_issueCnt, 1'b0});

   assign o_block_base = r_blockBase;

   // State, latched block base and both counters. Reset returns to IDLE with
   // everything cleared. Any in-flight fill is dropped without touching the tag.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_blockBase <= '0;
         r_issueCnt  <= '0;
         r_recvCnt   <= '0;
      end else begin
         r_state     <= w_nextState;
         r_blockBase <= w_nextBlockBase;
         r_issueCnt  <= w_nextIssueCnt;
         r_recvCnt   <= w_nextRecvCnt;
      end
   end

   // Next-state and output decode. In IDLE only a miss matters; returning
   // valids are ignored there. In FILL the issue side runs until all words are
   // requested, independent of the receive side. The receive side writes each
   // arriving word. The valid carrying the last word also writes the tag and
   // ends the fill. Every control output is forced low while reset is held.
   always_comb begin
      w_nextState        = r_state;
      w_nextBlockBase    = r_blockBase;
      w_nextIssueCnt     = r_issueCnt;
      w_nextRecvCnt      = r_recvCnt;
      o_fsm_busy         = 1'b0;
      o_memory_en        = 1'b0;
      o_memory_address   = '0;
      o_write_data_array = 1'b0;
      o_cache_word       = '0;
      o_cache_data       = '0;
      o_write_tag_array  = 1'b0;
      o_fill_done        = 1'b0;

      case (r_state)
         IDLE: begin
            if (i_miss_detected) begin
               w_nextState     = FILL;
               w_nextBlockBase = i_miss_address & BLK_MASK;
               w_nextIssueCnt  = CNT_ZERO;
               w_nextRecvCnt   = CNT_ZERO;
            end
         end

         FILL: begin
            o_fsm_busy = 1'b1;

            if (r_issueCnt < CNT_FULL) begin
               o_memory_en      = 1'b1;
               o_memory_address = w_issueAddr;
               w_nextIssueCnt   = r_issueCnt + CNT_ONE;
            end

            if (i_memory_data_valid) begin
               o_write_data_array = 1'b1;
               o_cache_word       = r_recvCnt[WORD_IDX_W-1:0];
               o_cache_data       = i_memory_data;
               w_nextRecvCnt      = r_recvCnt + CNT_ONE;
               if (r_recvCnt == CNT_LAST) begin
                  o_write_tag_array = 1'b1;
                  o_fill_done       = 1'b1;
                  w_nextState       = IDLE;
               end
            end
         end

         default: begin
            w_nextState = IDLE;
         end
      endcase

      if (i_rst) begin
         o_fsm_busy         = 1'b0;
         o_memory_en        = 1'b0;
         o_memory_address   = '0;
         o_write_data_array = 1'b0;
         o_cache_word       = '0;
         o_cache_data       = '0;
         o_write_tag_array  = 1'b0;
         o_fill_done        = 1'b0;
      end
   end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm
// Directed bench for cache_fill_fsm. It includes a small pipelined memory model
// with a fixed 4-cycle latency and an optional minimum gap between returned
// words. Returned data is a fixed function of the requested address, so every
// written word can be predicted from the expected request address.

module tb_cache_fill_fsm;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_miss_detected;
   logic [15:0] i_miss_address;
   logic        o_fsm_busy;
   logic        o_memory_en;
   logic [15:0] o_memory_address;
   logic        i_memory_data_valid;
   logic [15:0] i_memory_data;
   logic        o_write_data_array;
   logic [2:0]  o_cache_word;
   logic [15:0] o_cache_data;
   logic        o_write_tag_array;
   logic        o_fill_done;
   logic [15:0] o_block_base;

   int nChecks = 0;
   int nErrors = 0;
   int cycleNo = 0;
   int memGap = 0;
   int lastValid = -100;
   int writeCnt = 0;
   int tagCnt = 0;
   logic [15:0] addrQ[$];
   int dueQ[$];

   cache_fill_fsm #(.WORDS_PER_BLK(8), .ADDR_W(16)) dut (
      .i_clk               (i_clk),
      .i_rst               (i_rst),
      .i_miss_detected     (i_miss_detected),
      .i_miss_address      (i_miss_address),
      .o_fsm_busy          (o_fsm_busy),
      .o_memory_en         (o_memory_en),
      .o_memory_address    (o_memory_address),
      .i_memory_data_valid (i_memory_data_valid),
      .i_memory_data       (i_memory_data),
      .o_write_data_array  (o_write_data_array),
      .o_cache_word        (o_cache_word),
      .o_cache_data        (o_cache_data),
      .o_write_tag_array   (o_write_tag_array),
      .o_fill_done         (o_fill_done),
      .o_block_base        (o_block_base)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 i_clk = ~i_clk;

   // Memory contents: each word is its own address scrambled by a constant.
   function automatic logic [15:0] memWord(input logic [15:0] a);
      return a ^ 16'hC3A5;
   endfunction

   // One comparison: counts it and reports any disagreement.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nErrors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advances one clock. Before the edge it captures any request made this
   // cycle into the memory pipeline. After the edge it drives the memory
   // return for the new cycle.
   task automatic applyStimulus();
      if (o_memory_en === 1'b1) begin
         addrQ.push_back(o_memory_address);
         dueQ.push_back(cycleNo + 4);
      end
      @(posedge i_clk);
      cycleNo++;
      #1;
      if (dueQ.size() > 0 && dueQ[0] <= cycleNo && (cycleNo - lastValid) > memGap) begin
         i_memory_data_valid = 1'b1;
         i_memory_data       = memWord(addrQ[0]);
         void'(addrQ.pop_front());
         void'(dueQ.pop_front());
         lastValid = cycleNo;
      end else begin
         i_memory_data_valid = 1'b0;
         i_memory_data       = 16'($urandom);
      end
   endtask

   // All outputs must be zero while reset is held.
   task automatic checkAllZero(input string pfx);
      #1;
      checkOutput({pfx, " busy"}, 32'(o_fsm_busy), 32'd0);
      checkOutput({pfx, " memEn"}, 32'(o_memory_en), 32'd0);
      checkOutput({pfx, " memAddr"}, 32'(o_memory_address), 32'd0);
      checkOutput({pfx, " wrData"}, 32'(o_write_data_array), 32'd0);
      checkOutput({pfx, " word"}, 32'(o_cache_word), 32'd0);
      checkOutput({pfx, " data"}, 32'(o_cache_data), 32'd0);
      checkOutput({pfx, " wrTag"}, 32'(o_write_tag_array), 32'd0);
      checkOutput({pfx, " done"}, 32'(o_fill_done), 32'd0);
      checkOutput({pfx, " base"}, 32'(o_block_base), 32'd0);
   endtask

   // Expected behaviour in cycle c of a fill (c = 1 is the first FILL cycle).
   // Requests go out in cycles 1..8. Word i returns in cycle 5 + i*(gap+1).
   // The last word lands in cycle L, and the controller is idle in cycle L+1.
   task automatic checkCycle(input int c, input logic [15:0] base, input int gap);
      int          lastC;
      int          k;
      int          idx;
      bit          expW;
      logic [15:0] expAddr;
      lastC   = 5 + 7 * (gap + 1);
      k       = c - 5;
      idx     = (k >= 0) ? k / (gap + 1) : 0;
      expW    = (k >= 0) && (k % (gap + 1) == 0) && (idx <= 7);
      expAddr = base + 16'(2 * (c - 1));
      #1;
      if (o_write_data_array === 1'b1) writeCnt++;
      if (o_write_tag_array === 1'b1) tagCnt++;
      checkOutput($sformatf("c%0d busy", c), 32'(o_fsm_busy), 32'(c <= lastC));
      checkOutput($sformatf("c%0d memEn", c), 32'(o_memory_en), 32'(c <= 8));
      if (c <= 8)
         checkOutput($sformatf("c%0d memAddr", c), 32'(o_memory_address), 32'(expAddr));
      checkOutput($sformatf("c%0d wrData", c), 32'(o_write_data_array), 32'(expW));
      if (expW) begin
         checkOutput($sformatf("c%0d word", c), 32'(o_cache_word), 32'(idx));
         checkOutput($sformatf("c%0d data", c), 32'(o_cache_data),
                     32'(memWord(base + 16'(2 * idx))));
      end
      checkOutput($sformatf("c%0d wrTag", c), 32'(o_write_tag_array), 32'(c == lastC));
      checkOutput($sformatf("c%0d done", c), 32'(o_fill_done), 32'(c == lastC));
      if (c <= lastC)
         checkOutput($sformatf("c%0d base", c), 32'(o_block_base), 32'(base));
   endtask

   // Runs a whole fill from cycle 1 through the first idle cycle. It optionally
   // raises a competing miss in cycles 3-4, which the controller must ignore.
   task automatic runFill(input logic [15:0] base, input int gap, input bit inject);
      int lastC;
      lastC    = 5 + 7 * (gap + 1);
      writeCnt = 0;
      tagCnt   = 0;
      for (int c = 1; c <= lastC + 1; c++) begin
         if (c > 1) applyStimulus();
         if (inject && c == 3) begin
            i_miss_detected = 1'b1;
            i_miss_address  = 16'h4000;
         end else if (inject && c == 5) begin
            i_miss_detected = 1'b0;
         end
         checkCycle(c, base, gap);
      end
      checkOutput("fill writes", 32'(writeCnt), 32'd8);
      checkOutput("fill tag pulses", 32'(tagCnt), 32'd1);
   endtask

   // Directed sequence: reset, basic fill with a competing miss, idle valids,
   // address wrap, reset mid-fill, then gapped back-to-back fills.
   initial begin
      i_rst               = 1'b1;
      i_miss_detected     = 1'b1;
      i_miss_address      = 16'($urandom);
      i_memory_data_valid = 1'b1;
      i_memory_data       = 16'($urandom);

      // Reset held for two cycles with random inputs and a valid asserted.
      for (int r = 0; r < 2; r++) begin
         applyStimulus();
         i_miss_detected     = 1'($urandom);
         i_miss_address      = 16'($urandom);
         i_memory_data_valid = 1'b1;
         i_memory_data       = 16'($urandom);
         checkAllZero($sformatf("reset%0d", r));
      end
      applyStimulus();
      i_rst           = 1'b0;
      i_miss_detected = 1'b0;
      i_miss_address  = 16'h0000;
      applyStimulus();

      // Basic fill at 0x1234 with a competing miss at 0x4000 mid-fill.
      i_miss_address  = 16'h1234;
      i_miss_detected = 1'b1;
      applyStimulus();
      i_miss_detected = 1'b0;
      runFill(16'h1230, 0, 1'b1);

      // Valids while idle write nothing.
      for (int k = 0; k < 2; k++) begin
         applyStimulus();
         i_memory_data_valid = 1'b1;
         i_memory_data       = 16'hBEEF;
         #1;
         checkOutput($sformatf("idleValid%0d wrData", k), 32'(o_write_data_array), 32'd0);
         checkOutput($sformatf("idleValid%0d busy", k), 32'(o_fsm_busy), 32'd0);
         checkOutput($sformatf("idleValid%0d wrTag", k), 32'(o_write_tag_array), 32'd0);
      end
      applyStimulus();

      // Address wrap at the top of memory. Word order must also restart at 0
      // after the idle valids above.
      i_miss_address  = 16'hFFFB;
      i_miss_detected = 1'b1;
      applyStimulus();
      i_miss_detected = 1'b0;
      runFill(16'hFFF0, 0, 1'b0);

      // Reset in cycle 7 of a fill at 0x2000.
      i_miss_address  = 16'h2000;
      i_miss_detected = 1'b1;
      applyStimulus();
      i_miss_detected = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         if (c > 1) applyStimulus();
         checkCycle(c, 16'h2000, 0);
      end
      applyStimulus();
      i_rst = 1'b1;
      #1;
      checkOutput("midRst c7 busy", 32'(o_fsm_busy), 32'd0);
      checkOutput("midRst c7 memEn", 32'(o_memory_en), 32'd0);
      checkOutput("midRst c7 wrData", 32'(o_write_data_array), 32'd0);
      checkOutput("midRst c7 wrTag", 32'(o_write_tag_array), 32'd0);
      applyStimulus();
      i_rst = 1'b0;
      for (int c = 8; c <= 13; c++) begin
         if (c > 8) applyStimulus();
         #1;
         checkOutput($sformatf("midRst c%0d busy", c), 32'(o_fsm_busy), 32'd0);
         checkOutput($sformatf("midRst c%0d wrData", c), 32'(o_write_data_array), 32'd0);
         checkOutput($sformatf("midRst c%0d wrTag", c), 32'(o_write_tag_array), 32'd0);
         checkOutput($sformatf("midRst c%0d done", c), 32'(o_fill_done), 32'd0);
         if (c == 8)
            checkOutput("midRst c8 base", 32'(o_block_base), 32'd0);
      end

      // Gapped returns. The miss is held across completion, so a second fill
      // starts at the next edge after the controller returns to idle.
      addrQ.delete();
      dueQ.delete();
      memGap          = 2;
      i_miss_address  = 16'h8006;
      i_miss_detected = 1'b1;
      applyStimulus();
      runFill(16'h8000, 2, 1'b0);
      i_miss_address = 16'hABCD;
      applyStimulus();
      i_miss_detected = 1'b0;
      runFill(16'hABC0, 2, 1'b0);

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller between a cache (I- or D-side) and the shared 4-cycle pipelined main memory. On a cache miss it accepts the miss address, issues eight sequential word reads for the containing 16-byte block, and streams returned words into the cache data array. It writes the tag array when the final word lands. The CPU-side arbiter instantiates one per cache and muxes memory ownership on `fsm_busy`.

## Interface
- `WORDS_PER_BLK`, 8, words per cache block; the block is 2*WORDS_PER_BLK bytes.
- `ADDR_W`, 16, byte-address width.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `miss_detected`  in  1  cache miss request; level, sampled only in IDLE.
- `miss_address`  in  16  byte address of the missing access.
- `fsm_busy`  out  1  high while a fill is in progress (state FILL).
- `memory_en`  out  1  memory read request this cycle.
- `memory_address`  out  16  word-aligned byte address of the current request.
- `memory_data_valid`  in  1  memory returns one word this cycle.
- `memory_data`  in  16  returned word, valid with `memory_data_valid`.
- `write_data_array`  out  1  write `cache_data` into word `cache_word` of the block.
- `cache_word`  out  3  word index within the block.
- `cache_data`  out  16  data to write; equals `memory_data`.
- `write_tag_array`  out  1  one-cycle pulse: write tag and valid for `block_base`.
- `fill_done`  out  1  one-cycle pulse, coincident with `write_tag_array`.
- `block_base`  out  16  latched base address, `miss_address & 16'hFFF0`.

## Operation
- States: IDLE, FILL. Reset forces IDLE; `issue_cnt` = 0; `recv_cnt` = 0; `block_base` = 0.
- IDLE + `miss_detected`: latch `block_base` and clear both counters, then go to FILL at the next edge. IDLE without a miss holds.
- FILL issue side: `memory_en` = (`issue_cnt` < 8). `memory_address` = `block_base` + 2*`issue_cnt`, computed modulo 2^16 with no carry out of bit 15. `issue_cnt` increments each issuing cycle and saturates at 8.
- FILL receive side: each `memory_data_valid` asserts `write_data_array`, with `cache_word` = `recv_cnt[2:0]` and `cache_data` = `memory_data`. `recv_cnt` then increments.
- Completion: the valid with `recv_cnt` = 7 also asserts `write_tag_array` and `fill_done` in that same cycle. The state returns to IDLE at the next edge.
- Issue and receive overlap: data for early words returns while later requests are still issuing.
- `miss_detected` is ignored during FILL.
- `memory_data_valid` in IDLE is ignored: no writes and no counter change.
- Reset mid-fill aborts the fill. The tag is not written, so the block stays invalid. Later stray valids are ignored.
- The outputs `memory_en`, `write_data_array`, `write_tag_array`, `fill_done` and `fsm_busy` are all 0 in IDLE and under reset.

## Timing
- Miss sampled at edge E0. FILL begins in cycle 1 after E0, and `fsm_busy` = 1 from cycle 1.
- Requests issue in cycles 1 through 8, one per cycle, in consecutive cycles with no bubbles.
- With memory latency 4, word i returns in cycle 5+i. The last word, together with the tag write and `fill_done`, lands in cycle 12. `fsm_busy` = 0 in cycle 13.
- Correctness depends only on valid count, not on latency. The FSM tolerates gaps between valids.
- A new miss asserted in cycle 13 (IDLE) is accepted, and FILL begins in cycle 14.

## Test plan
- Reset values: assert `rst` for 2 cycles with random inputs, including `memory_data_valid` = 1. All outputs must be 0 and `block_base` must be 0x0000.
- Basic fill with a 4-cycle memory model: miss at 0x1234. Requests must go to 0x1230, 0x1232 … 0x123E in cycles 1–8. Words 0–7 must be written in cycles 5–12. `write_tag_array` and `fill_done` must pulse in cycle 12, and `fsm_busy` must drop in cycle 13.
- Address wrap: miss at 0xFFFB. `block_base` must be 0xFFF0 and the last request 0xFFFE, with no carry.
- Ignored inputs:
  - Pulse `memory_data_valid` in IDLE: no `write_data_array` and no counter change.
  - Assert a second miss (0x4000) during FILL: `block_base` stays 0x1230.
- Reset mid-fill: reset in cycle 7 of a fill. The FSM must be in IDLE the next cycle, with no `write_tag_array`. Valids still returning afterward must produce no writes.
- Back-to-back with gapped returns: the memory model inserts 2-cycle gaps between valids. The fill must still complete with 8 writes and exactly one tag pulse. A miss held high across completion must start a new fill at the next edge.
